// File: rtl/game_pkg.sv
// Shared encodings for the fighting game: player actions, winner codes and
// the round sequencer state machine.
package game_pkg;

  typedef enum logic [2:0] {
    ACT_KICK   = 3'b000,
    ACT_PUNCH  = 3'b001,
    ACT_AWAIT  = 3'b010,
    ACT_JUMP   = 3'b011,
    ACT_LEFT1  = 3'b100,
    ACT_LEFT2  = 3'b101,
    ACT_RIGHT1 = 3'b110,
    ACT_RIGHT2 = 3'b111
  } action_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_FIRE    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability counter and one-cycle rising-edge pulse
// for a raw push button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // The debounced level only follows the synchronized input after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    sync_d  = {sync_q[0], btn};
    db_d    = db_q;
    cnt_d   = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    pulse_d = db_d & ~db_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/round_controller.sv
// Round sequencer: collects both players' committed actions, strobes them into
// the player blocks and decides game over. Optional collect timeout: ROUND_TIMEOUT_EN.
module round_controller
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ENABLE_CYCLES   = 2,
  parameter int SETTLE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       commit1,
  input  logic       commit2,
  input  logic [2:0] sw1,
  input  logic [2:0] sw2,
  input  logic [1:0] health1,
  input  logic [1:0] health2,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       ready1,
  output logic       ready2,
  output logic       isGameOver,
  output logic [1:0] winner,
  output logic [7:0] round_count
);

  localparam int PH_MAX = (ENABLE_CYCLES > SETTLE_CYCLES) ? ENABLE_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      action1_q, action1_d, action2_q, action2_d;
  logic            ready1_q, ready1_d, ready2_q, ready2_d;
  logic            en_q, en_d, over_q, over_d;
  logic [1:0]      winner_q, winner_d;
  logic [7:0]      round_q, round_d;
  logic            pulse1_s, pulse2_s, timeout_s;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk(clk), .reset(reset), .btn(commit1), .pulse(pulse1_s)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clk(clk), .reset(reset), .btn(commit2), .pulse(pulse2_s)
  );

`ifdef ROUND_TIMEOUT_EN
  logic [27:0] tmo_q, tmo_d;

  // Counts COLLECT cycles; any other state parks it at zero for the next round.
  always_comb begin
    if (state_q == ST_COLLECT) begin
      tmo_d = tmo_q + 28'd1;
    end else begin
      tmo_d = 28'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= 28'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign timeout_s = (state_q == ST_COLLECT) && (tmo_q == 28'(TIMEOUT_CYCLES - 1));
`else
  // No timeout: COLLECT waits for both players indefinitely.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    action1_d = action1_q;
    action2_d = action2_q;
    ready1_d  = ready1_q;
    ready2_d  = ready2_q;
    winner_d  = winner_q;
    round_d   = round_q;
    case (state_q)
      ST_COLLECT: begin
        // A real commit wins over a timeout-forced await in the same cycle.
        if (!ready1_q && pulse1_s) begin
          action1_d = sw1;
          ready1_d  = 1'b1;
        end else if (!ready1_q && timeout_s) begin
          action1_d = ACT_AWAIT;
          ready1_d  = 1'b1;
        end else begin
          action1_d = action1_q;
        end
        if (!ready2_q && pulse2_s) begin
          action2_d = sw2;
          ready2_d  = 1'b1;
        end else if (!ready2_q && timeout_s) begin
          action2_d = ACT_AWAIT;
          ready2_d  = 1'b1;
        end else begin
          action2_d = action2_q;
        end
        if (ready1_q && ready2_q) begin
          state_d = ST_FIRE;
          phase_d = '0;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_FIRE: begin
        if (phase_q == PH_W'(ENABLE_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_SETTLE: begin
        if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_CHECK: begin
        if ((health1 == 2'b00) || (health2 == 2'b00)) begin
          state_d  = ST_OVER;
          winner_d = {health1 == 2'b00, health2 == 2'b00};
        end else begin
          state_d  = ST_COLLECT;
          round_d  = sat_inc8(round_q);
          ready1_d = 1'b0;
          ready2_d = 1'b0;
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
    en_d   = (state_d == ST_FIRE);
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_COLLECT;
      phase_q   <= '0;
      action1_q <= ACT_AWAIT;
      action2_q <= ACT_AWAIT;
      ready1_q  <= 1'b0;
      ready2_q  <= 1'b0;
      en_q      <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= WIN_NONE;
      round_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      action1_q <= action1_d;
      action2_q <= action2_d;
      ready1_q  <= ready1_d;
      ready2_q  <= ready2_d;
      en_q      <= en_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      round_q   <= round_d;
    end
  end

  assign action1      = action1_q;
  assign action2      = action2_q;
  assign actionEnable = en_q;
  assign ready1       = ready1_q;
  assign ready2       = ready2_q;
  assign isGameOver   = over_q;
  assign winner       = winner_q;
  assign round_count  = round_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: table of full rounds plus
// hand-written sequences for locking, bounce, held buttons, reset and timeout.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       commit1 = 1'b0, commit2 = 1'b0;
  logic [2:0] sw1 = 3'b000, sw2 = 3'b000;
  logic [1:0] health1 = 2'b11, health2 = 2'b11;
  logic [2:0] action1, action2;
  logic       actionEnable, ready1, ready2, isGameOver;
  logic [1:0] winner;
  logic [7:0] round_count;

  int checks = 0;
  int errors = 0;
  int en_rise = 0;
  int en_hi = 0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  round_controller #(
    .DEBOUNCE_CYCLES(4), .ENABLE_CYCLES(2), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .commit1(commit1), .commit2(commit2),
    .sw1(sw1), .sw2(sw2), .health1(health1), .health2(health2),
    .action1(action1), .action2(action2), .actionEnable(actionEnable),
    .ready1(ready1), .ready2(ready2), .isGameOver(isGameOver),
    .winner(winner), .round_count(round_count)
  );

  // Counts strobe rising edges and high cycles.
  always @(negedge clk) begin
    if (actionEnable) en_hi <= en_hi + 1;
    if (actionEnable && !en_prev) en_rise <= en_rise + 1;
    en_prev <= actionEnable;
  end

  typedef struct {
    logic       rst;
    logic [2:0] s1, s2;
    logic [1:0] h1, h2;
    logic [2:0] a1, a2;
    logic       ov;
    logic [1:0] w;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int p);
    if (p == 1) commit1 = 1'b1; else commit2 = 1'b1;
    cycles(12);
    if (p == 1) commit1 = 1'b0; else commit2 = 1'b0;
    cycles(12);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    commit1 = 1'b0;
    commit2 = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_action1"}, 32'(action1), 32'h2);
    chk({tag, "_action2"}, 32'(action2), 32'h2);
    chk({tag, "_enable"}, 32'(actionEnable), 32'h0);
    chk({tag, "_ready"}, 32'({ready1, ready2}), 32'h0);
    chk({tag, "_over"}, 32'(isGameOver), 32'h0);
    chk({tag, "_winner"}, 32'(winner), 32'h0);
    chk({tag, "_rounds"}, 32'(round_count), 32'h0);
  endtask

  initial begin
    int r0;
    int h0;
    logic seen;
    tbl[0] = '{1'b1, 3'b000, 3'b101, 2'b11, 2'b11, 3'b000, 3'b101, 1'b0, 2'b00, 8'd1};
    tbl[1] = '{1'b0, 3'b011, 3'b110, 2'b10, 2'b01, 3'b011, 3'b110, 1'b0, 2'b00, 8'd2};
    tbl[2] = '{1'b0, 3'b111, 3'b001, 2'b01, 2'b01, 3'b111, 3'b001, 1'b0, 2'b00, 8'd3};
    tbl[3] = '{1'b0, 3'b100, 3'b010, 2'b11, 2'b00, 3'b100, 3'b010, 1'b1, 2'b01, 8'd3};
    tbl[4] = '{1'b1, 3'b001, 3'b011, 2'b00, 2'b10, 3'b001, 3'b011, 1'b1, 2'b10, 8'd0};
    tbl[5] = '{1'b1, 3'b110, 3'b100, 2'b00, 2'b00, 3'b110, 3'b100, 1'b1, 2'b11, 8'd0};

    do_reset();
    chk_reset_vals("reset");

    // Full rounds from the table.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      health1 = tbl[i].h1;
      health2 = tbl[i].h2;
      r0 = en_rise;
      h0 = en_hi;
      sw1 = tbl[i].s1;
      press(1);
      sw2 = tbl[i].s2;
      press(2);
      cycles(10);
      chk($sformatf("row%0d_action1", i), 32'(action1), 32'(tbl[i].a1));
      chk($sformatf("row%0d_action2", i), 32'(action2), 32'(tbl[i].a2));
      chk($sformatf("row%0d_over", i), 32'(isGameOver), 32'(tbl[i].ov));
      chk($sformatf("row%0d_winner", i), 32'(winner), 32'(tbl[i].w));
      chk($sformatf("row%0d_rounds", i), 32'(round_count), 32'(tbl[i].rc));
      chk($sformatf("row%0d_ready", i), 32'({ready1, ready2}), tbl[i].ov ? 32'h3 : 32'h0);
      chk($sformatf("row%0d_pulses", i), 32'(en_rise - r0), 32'd1);
      chk($sformatf("row%0d_en_cycles", i), 32'(en_hi - h0), 32'd2);
    end

    // Commits after game over are ignored.
    r0 = en_rise;
    sw1 = 3'b000;
    sw2 = 3'b000;
    press(1);
    press(2);
    cycles(10);
    chk("over_action1", 32'(action1), 32'h6);
    chk("over_action2", 32'(action2), 32'h4);
    chk("over_held", 32'({isGameOver, winner}), 32'h7);
    chk("over_no_pulse", 32'(en_rise - r0), 32'd0);

    // Asynchronous reset returns everything to reset values.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    cycles(2);
    reset = 1'b1;
    cycles(2);

    // First commit locks the action for the round.
    health1 = 2'b11;
    health2 = 2'b11;
    r0 = en_rise;
    sw1 = 3'b001;
    press(1);
    chk("lock_ready", 32'({ready1, ready2}), 32'h2);
    chk("lock_first", 32'(action1), 32'h1);
    sw1 = 3'b000;
    press(1);
    chk("lock_kept", 32'(action1), 32'h1);
    sw2 = 3'b010;
    press(2);
    cycles(10);
    chk("lock_action1", 32'(action1), 32'h1);
    chk("lock_rounds", 32'(round_count), 32'd1);
    chk("lock_pulses", 32'(en_rise - r0), 32'd1);

    // A 2-cycle glitch must not register.
    commit1 = 1'b1;
    cycles(2);
    commit1 = 1'b0;
    cycles(12);
    chk("glitch_ready1", 32'(ready1), 32'h0);

    // A button held across rounds commits only once.
    r0 = en_rise;
    sw1 = 3'b111;
    commit1 = 1'b1;
    cycles(12);
    sw2 = 3'b100;
    press(2);
    cycles(10);
    chk("hold_first_round", 32'(en_rise - r0), 32'd1);
    chk("hold_action1", 32'(action1), 32'h7);
    press(2);
    press(2);
    cycles(10);
    chk("hold_no_more", 32'(en_rise - r0), 32'd1);
    chk("hold_ready", 32'({ready1, ready2}), 32'h1);
    chk("hold_rounds", 32'(round_count), 32'd2);
    commit1 = 1'b0;
    cycles(12);

    // Simultaneous commits, then reset while the strobe is high.
    do_reset();
    sw1 = 3'b011;
    sw2 = 3'b110;
    commit1 = 1'b1;
    commit2 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (actionEnable) begin
        seen = 1'b1;
        break;
      end
    end
    chk("both_fire_seen", 32'(seen), 32'h1);
    chk("both_actions", 32'({action1, action2}), 32'h1e);
    reset = 1'b0;
    #1;
    chk("midfire_enable", 32'(actionEnable), 32'h0);
    chk("midfire_rounds", 32'(round_count), 32'd0);
    commit1 = 1'b0;
    commit2 = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(2);

    // Only one player commits.
    do_reset();
    r0 = en_rise;
    sw1 = 3'b011;
    sw2 = 3'b101;
    press(1);
    chk("tmo_early_no_pulse", 32'(en_rise - r0), 32'd0);
`ifdef ROUND_TIMEOUT_EN
    cycles(60);
    chk("tmo_pulses", 32'(en_rise - r0), 32'd1);
    chk("tmo_action1", 32'(action1), 32'h3);
    chk("tmo_action2", 32'(action2), 32'h2);
    chk("tmo_rounds", 32'(round_count), 32'd1);
`else
    cycles(1000);
    chk("notmo_pulses", 32'(en_rise - r0), 32'd0);
    chk("notmo_ready", 32'({ready1, ready2}), 32'h2);
    chk("notmo_action2", 32'(action2), 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_controller.md
# round_controller

Upstream sequencer for the two-player fighting game. Captures each player's 3-bit action from switches on a debounced commit button, waits until both players have committed (or a round timeout expires), then drives `action1`/`action2` with a single `actionEnable` pulse into the player blocks. After each round it samples both health buses and raises `isGameOver` with a winner code.

## Interface
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronized button must be stable before it counts as pressed.
- `ENABLE_CYCLES`, 2: width of the `actionEnable` high pulse, in cycles; minimum 1.
- `SETTLE_CYCLES`, 2: low cycles after the pulse before health is sampled; minimum 1.
- `TIMEOUT_CYCLES`, 250000000: collect-phase timeout; used only with `ROUND_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `commit1`, `commit2` in 1: raw, asynchronous push buttons; active-high.
- `sw1`, `sw2` in 3: raw action switches for each player.
- `health1`, `health2` in 2: health from the player blocks.
- `action1`, `action2` out 3: latched actions.
- `actionEnable` out 1: round strobe to the player blocks.
- `ready1`, `ready2` out 1: player has committed this round (LEDs).
- `isGameOver` out 1: game finished.
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw.
- `round_count` out 8: completed rounds; saturates at 255.

## Operation
- Reset values: `action1` = `action2` = 3'b010 (await). `actionEnable`, `ready1`, `ready2`, `isGameOver` = 0. `winner` = 00. `round_count` = 0. FSM in COLLECT.
- COLLECT:
  - A debounced commit pulse for player n latches `swn` into `actionn` and sets `readyn`, only if `readyn` = 0.
  - Later commits in the same round are ignored. The first commit locks the action.
  - When `ready1` and `ready2` are both 1, go to FIRE on the next cycle.
- FIRE: `actionEnable` = 1 for exactly `ENABLE_CYCLES` cycles. Actions are held constant. Then go to SETTLE.
- SETTLE: `actionEnable` = 0 for `SETTLE_CYCLES` cycles. Then go to CHECK.
- CHECK (1 cycle), based on `health1`/`health2`:
  - Either health is 0: go to OVER. Set `winner` to 01 if only `health2` = 0, 10 if only `health1` = 0, 11 if both are 0.
  - Otherwise: `round_count` += 1 (saturating), clear `ready1`/`ready2`, return to COLLECT.
  - Actions keep their last values until the next commit.
- OVER: `isGameOver` = 1 and `winner` is held. All commits are ignored. Exit only via `reset`.
- Commit pulses that arrive outside COLLECT are dropped, not queued.
- A button held down across rounds produces no new pulse; the player must release and press again.
- If both commits arrive in the same cycle, both latch and the next state is FIRE.

## Timing
- Button to internal pulse: 2-flop synchronizer plus `DEBOUNCE_CYCLES` stable cycles, then a 1-cycle pulse on the rising edge.
- `readyn` and `actionn` update on the cycle after the pulse.
- Both ready to `actionEnable` rising edge: 1 cycle.
- Round length from the last commit to re-entry into COLLECT: 1 + `ENABLE_CYCLES` + `SETTLE_CYCLES` + 1 cycles.
- `isGameOver` is asserted on the cycle after CHECK.
- Reset mid-FIRE: `actionEnable` drops asynchronously, with no partial-round bookkeeping.
- All outputs are registered.

## Configuration
- Macro: `ROUND_TIMEOUT_EN`.
- Defined:
  - A 28-bit counter clears on entry to COLLECT and increments every COLLECT cycle.
  - When it reaches `TIMEOUT_CYCLES-1`, every non-ready player is forced to await (3'b010) with `readyn` = 1, and FIRE follows.
  - A commit in that same cycle takes priority: that player's switch value latches.
- Undefined: no counter. COLLECT waits indefinitely.

## Structure
- The shared package `game_pkg` holds:
  - action encodings: kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111;
  - winner codes;
  - FSM state encoding: COLLECT, FIRE, SETTLE, CHECK, OVER.
- One sub-module, `button_debounce`: synchronizer, stability counter and rising-edge pulse. Instantiated twice.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `ENABLE_CYCLES`=2, `SETTLE_CYCLES`=2, `TIMEOUT_CYCLES`=50.
- Reset check: after reset, `action1`/`action2` = 010, `actionEnable` = 0, `round_count` = 0.
- Normal round: `sw1`=000, press `commit1`; `sw2`=101, press `commit2` -> `action1`=000, `action2`=101, `actionEnable` high exactly 2 cycles, `round_count`=1, `ready1`/`ready2` clear.
- Locked action: P1 commits 001, then commits 000 before P2 commits -> `action1` stays 001.
- Bounce rejection: a 2-cycle glitch on `commit1` -> no latch. Holding the button for 3 rounds -> only one commit.
- Game over: `health2`=00 at CHECK -> `isGameOver`=1, `winner`=01, later commits ignored. Both healths 00 -> `winner`=11. `reset` low -> all outputs return to reset values.
- Timeout, with `ROUND_TIMEOUT_EN` defined: P1 commits 011, P2 idle for 50 cycles -> `action2`=010, pulse fires. Without the macro -> no pulse after 1000 cycles.
